// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit framer.
// Optional macro UART_TX_TWO_STOP_EN (see uart_tx_frame) uses the STOP2 state.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        STOP2
    } tx_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

    localparam int unsigned MAX_DATA_WIDTH = 9;

    // Narrower payloads are zero-extended; padding zeros do not change the XOR.
    function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] d,
                                         input logic                      typ);
        logic r;
        case (typ)
            PAR_EVEN: r = ^d;
            PAR_ODD:  r = ~(^d);
            default:  r = ^d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and data-bit counter for the UART transmit framer.
// Loads on i_load, shifts right on i_shift_en; o_ser_done marks the last data bit.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_shift_en,
    input  logic                  i_cnt_clr,
    output logic                  o_ser_bit,
    output logic                  o_ser_done
);

    localparam int unsigned       CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
        end else if (i_shift_en) begin
            r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
        end
    end

    // Counter tracks the index of the bit currently on the line and saturates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load || i_cnt_clr) begin
            r_cnt <= '0;
        end else if (i_shift_en && (r_cnt != CNT_LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_ser_bit  = r_shift[0];
    assign o_ser_done = (r_cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first data, optional parity, stop bit(s).
// Define UART_TX_TWO_STOP_EN to transmit two stop bits (adds the STOP2 state).
module uart_tx_frame
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy
);

    tx_state_e r_state;
    tx_state_e w_next_state;

    logic r_tx_out;
    logic r_busy;
    logic r_par_en;
    logic r_par_bit;

    logic w_next_tx;
    logic w_load;
    logic w_shift;
    logic w_cnt_clr;
    logic w_ser_bit;
    logic w_ser_done;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_data     (p_data),
        .i_shift_en (w_shift),
        .i_cnt_clr  (w_cnt_clr),
        .o_ser_bit  (w_ser_bit),
        .o_ser_done (w_ser_done)
    );

    // The line value is computed for the state being entered, so tx_out is a pure register.
    always_comb begin
        w_next_state = r_state;
        w_next_tx    = LINE_IDLE;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_cnt_clr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (data_valid) begin
                    w_next_state = START;
                    w_next_tx    = START_BIT;
                    w_load       = 1'b1;
                end
            end
            START: begin
                w_next_state = DATA;
                w_next_tx    = w_ser_bit;
                w_shift      = 1'b1;
                w_cnt_clr    = 1'b1;
            end
            DATA: begin
                if (w_ser_done) begin
                    if (r_par_en) begin
                        w_next_state = PARITY;
                        w_next_tx    = r_par_bit;
                    end else begin
                        w_next_state = STOP;
                        w_next_tx    = LINE_IDLE;
                    end
                end else begin
                    w_next_tx = w_ser_bit;
                    w_shift   = 1'b1;
                end
            end
            PARITY: begin
                w_next_state = STOP;
                w_next_tx    = LINE_IDLE;
            end
`ifdef UART_TX_TWO_STOP_EN
            STOP: begin
                w_next_state = STOP2;
                w_next_tx    = LINE_IDLE;
            end
            STOP2: begin
                w_next_state = IDLE;
                w_next_tx    = LINE_IDLE;
            end
`else
            STOP: begin
                w_next_state = IDLE;
                w_next_tx    = LINE_IDLE;
            end
`endif
            default: begin
                w_next_state = IDLE;
                w_next_tx    = LINE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_tx_out <= LINE_IDLE;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_tx_out <= w_next_tx;
            r_busy   <= (w_next_state != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else if (w_load) begin
            r_par_en  <= par_en;
            r_par_bit <= calc_parity(MAX_DATA_WIDTH'(p_data), par_typ);
        end
    end

    assign tx_out = r_tx_out;
    assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: expected line/busy samples are queued per frame.
module tb_uart_tx_frame;

    localparam int DW = 8;
`ifdef UART_TX_TWO_STOP_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif

    typedef struct packed {
        logic tx;
        logic busy;
    } line_t;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic [DW-1:0] p_data     = '0;
    logic          data_valid = 1'b0;
    logic          par_en     = 1'b0;
    logic          par_typ    = 1'b0;
    logic          tx_out;
    logic          busy;

    line_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got running, want finished)");
        $fatal(1);
    end

    // Expected samples from the cycle after accept through the following idle cycle.
    function automatic void push_frame(input logic [DW-1:0] d, input logic pen, input logic ptyp);
        sb.push_back(line_t'{1'b0, 1'b1});
        for (int i = 0; i < DW; i++) sb.push_back(line_t'{d[i], 1'b1});
        if (pen) sb.push_back(line_t'{(^d) ^ ptyp, 1'b1});
        for (int i = 0; i < STOP_BITS; i++) sb.push_back(line_t'{1'b1, 1'b1});
        sb.push_back(line_t'{1'b1, 1'b0});
    endfunction

    task automatic request(input logic [DW-1:0] d, input logic pen, input logic ptyp);
        @(negedge clk);
        p_data     = d;
        par_en     = pen;
        par_typ    = ptyp;
        data_valid = 1'b1;
        push_frame(d, pen, ptyp);
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        data_valid = 1'b1;
        p_data     = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if ({tx_out, busy} !== 2'b10) begin
                n_err++;
                $display("FAIL reset_hold[%0d]: got tx=%b busy=%b want tx=1 busy=0", i, tx_out, busy);
            end
        end
        data_valid = 1'b0;
        rst        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if ({tx_out, busy} !== 2'b10) begin
                n_err++;
                $display("FAIL reset_release[%0d]: got tx=%b busy=%b want tx=1 busy=0", i, tx_out, busy);
            end
        end
    endtask

    task automatic test_even_parity;
        line_t       e;
        int          k = 0;
        int          busy_cycles = 0;
        logic [10:0] got = '0;
        logic [10:0] want = 11'b10101001010;
        request(8'hA5, 1'b1, 1'b0);
        while (sb.size() > 0) begin
            @(negedge clk);
            data_valid = 1'b0;
            e = sb.pop_front();
            if (k < 11) got[k] = tx_out;
            if (busy === 1'b1) busy_cycles++;
            n_vec++;
            if ({tx_out, busy} !== e) begin
                n_err++;
                $display("FAIL even_a5[%0d]: got tx=%b busy=%b want tx=%b busy=%b", k, tx_out, busy, e.tx, e.busy);
            end
            k++;
        end
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL even_a5_bits: got %b want %b (bit0 first)", got, want);
        end
        n_vec++;
        if (busy_cycles !== 3 + DW + STOP_BITS - 1) begin
            n_err++;
            $display("FAIL even_a5_len: got %0d want %0d", busy_cycles, 3 + DW + STOP_BITS - 1);
        end
    endtask

    task automatic test_odd_parity;
        line_t e;
        int    k;
        for (int pass = 0; pass < 2; pass++) begin
            k = 0;
            request(8'hA5, 1'b1, 1'b1);
            while (sb.size() > 0) begin
                @(negedge clk);
                data_valid = 1'b0;
                e = sb.pop_front();
                n_vec++;
                if ({tx_out, busy} !== e) begin
                    n_err++;
                    $display("FAIL odd_a5_p%0d[%0d]: got tx=%b busy=%b want tx=%b busy=%b", pass, k, tx_out, busy, e.tx, e.busy);
                end
                if (pass == 1 && k == 3) begin
                    par_typ = 1'b0;
                    p_data  = 8'h00;
                end
                k++;
            end
        end
    endtask

    task automatic test_no_parity;
        line_t e;
        int    k = 0;
        request(8'h3C, 1'b0, 1'b1);
        while (sb.size() > 0) begin
            @(negedge clk);
            data_valid = 1'b0;
            e = sb.pop_front();
            n_vec++;
            if ({tx_out, busy} !== e) begin
                n_err++;
                $display("FAIL nopar_3c[%0d]: got tx=%b busy=%b want tx=%b busy=%b", k, tx_out, busy, e.tx, e.busy);
            end
            k++;
        end
    endtask

    task automatic test_back_to_back;
        line_t e;
        int    k = 0;
        request(8'h01, 1'b0, 1'b0);
        push_frame(8'h01, 1'b0, 1'b0);
        push_frame(8'h01, 1'b0, 1'b0);
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            n_vec++;
            if ({tx_out, busy} !== e) begin
                n_err++;
                $display("FAIL b2b[%0d]: got tx=%b busy=%b want tx=%b busy=%b", k, tx_out, busy, e.tx, e.busy);
            end
            if (k % (DW + 2 + STOP_BITS) == 3) p_data = 8'hFE;
            if (k % (DW + 2 + STOP_BITS) == 7) p_data = 8'h01;
            if (sb.size() == 0) data_valid = 1'b0;
            k++;
        end
        @(negedge clk);
        n_vec++;
        if ({tx_out, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL b2b_stop: got tx=%b busy=%b want tx=1 busy=0", tx_out, busy);
        end
    endtask

    task automatic test_reset_mid_frame;
        line_t e;
        int    k = 0;
        request(8'hA5, 1'b1, 1'b0);
        while (k < 6) begin
            @(negedge clk);
            data_valid = 1'b0;
            e = sb.pop_front();
            n_vec++;
            if ({tx_out, busy} !== e) begin
                n_err++;
                $display("FAIL abort_pre[%0d]: got tx=%b busy=%b want tx=%b busy=%b", k, tx_out, busy, e.tx, e.busy);
            end
            k++;
        end
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({tx_out, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL abort_async: got tx=%b busy=%b want tx=1 busy=0", tx_out, busy);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_vec++;
            if ({tx_out, busy} !== 2'b10) begin
                n_err++;
                $display("FAIL abort_idle[%0d]: got tx=%b busy=%b want tx=1 busy=0", i, tx_out, busy);
            end
        end
        k = 0;
        request(8'h5A, 1'b1, 1'b1);
        while (sb.size() > 0) begin
            @(negedge clk);
            data_valid = 1'b0;
            e = sb.pop_front();
            n_vec++;
            if ({tx_out, busy} !== e) begin
                n_err++;
                $display("FAIL abort_next[%0d]: got tx=%b busy=%b want tx=%b busy=%b", k, tx_out, busy, e.tx, e.busy);
            end
            k++;
        end
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_no_parity();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
